// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-subset control unit: a state register walks IF/ID/EXE/MEM/WB
// per instruction; all control outputs decode combinationally from state and IR fields.
module multi_cycle_control (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       RegDst,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLL = 6'b000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;

  logic is_rtype, is_imm, is_lw, is_sw, is_branch, br_taken, recognised;

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Selects depend only on the IR fields, so they stay stable for the whole instruction.
  always_comb begin
    is_rtype  = 1'b0;
    is_imm    = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_branch = 1'b0;
    br_taken  = 1'b0;
    ALUOp     = ALU_ADD;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_ADD: begin is_rtype = 1'b1; ALUOp = ALU_ADD; end
          F_SUB: begin is_rtype = 1'b1; ALUOp = ALU_SUB; end
          F_AND: begin is_rtype = 1'b1; ALUOp = ALU_AND; end
          F_OR:  begin is_rtype = 1'b1; ALUOp = ALU_OR;  end
          F_SLL: begin is_rtype = 1'b1; ALUOp = ALU_SLL; ALUSrcA = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin is_imm = 1'b1; ALUOp = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1; end
      OP_ANDI: begin is_imm = 1'b1; ALUOp = ALU_AND; ALUSrcB = 1'b1; end
      OP_ORI:  begin is_imm = 1'b1; ALUOp = ALU_OR;  ALUSrcB = 1'b1; end
      OP_SLTI: begin is_imm = 1'b1; ALUOp = ALU_SLT; ALUSrcB = 1'b1; ExtSel = 1'b1; end
      OP_LW:   begin is_lw  = 1'b1; ALUOp = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1; end
      OP_SW:   begin is_sw  = 1'b1; ALUOp = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1; end
      OP_BEQ:  begin is_branch = 1'b1; ALUOp = ALU_SUB; ExtSel = 1'b1; br_taken = zero;  end
      OP_BNE:  begin is_branch = 1'b1; ALUOp = ALU_SUB; ExtSel = 1'b1; br_taken = ~zero; end
      OP_BLTZ: begin is_branch = 1'b1; ALUOp = ALU_ADD; ExtSel = 1'b1; br_taken = sign;  end
      default: ;
    endcase
    recognised = is_rtype | is_imm | is_lw | is_sw | is_branch;
  end

  assign RegDst    = is_rtype;
  assign DBDataSrc = is_lw;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    PCWre   = 1'b0;
    IRWre   = 1'b0;
    RegWre  = 1'b0;
    mRD     = 1'b0;
    mWR     = 1'b0;
    PCSrc   = 2'b00;
    case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (op == OP_J) begin
          PCWre   = 1'b1;
          PCSrc   = 2'b10;
          state_d = S_IF;
        end else if (op == OP_HALT) begin
          state_d = S_HALT;
        end else if (recognised) begin
          state_d = S_EXE;
        end else begin
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end
      S_EXE: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          // Branches always retire here, so the PC is written even when not taken.
          PCWre   = 1'b1;
          PCSrc   = br_taken ? 2'b01 : 2'b00;
          state_d = S_IF;
        end else if (recognised) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          mRD     = 1'b1;
          state_d = S_WB;
        end else if (is_sw) begin
          mWR     = 1'b1;
          PCWre   = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        RegWre  = 1'b1;
        PCWre   = 1'b1;
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    // Reset blanks every write enable in the cycle it is seen, whatever the state.
    if (Reset) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
    end
  end

endmodule
